// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter: FSM state, read-response tag
// and the round-robin pointer advance.
package sram_arb_pkg;

  // Tag index is sized for the largest supported requester count (8).
  localparam int unsigned TAG_IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } rsp_tag_t;

  function automatic logic [TAG_IDX_W-1:0] rr_next(input logic [TAG_IDX_W-1:0] ptr,
                                                   input int unsigned n);
    logic [TAG_IDX_W-1:0] nxt;
    if (32'(ptr) + 32'd1 >= n) nxt = '0;
    else nxt = ptr + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, cyclically.
module sram_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Two passes: indices at/after the pointer win, then wrap around to the low ones.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!any_o && valid_i[i] && (i >= int'(ptr_i))) begin
        any_o      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!any_o && valid_i[i]) begin
        any_o      = 1'b1;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one fixed-latency single-port SRAM between NUM_REQ requesters with round-robin
// grant, burst locking and tagged routing of read data back to the issuer.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned SRAM_LATENCY = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  // Beat handshake: a beat moves when req_valid_i[i] & req_ready_o[i]. Ready is
  // combinational from valid and state, so valid must never wait on ready.
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_we_i,
  input  logic [NUM_REQ-1:0]              req_last_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_be_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [ADDR_WIDTH-1:0]           sram_addr_o,
  output logic [DATA_WIDTH-1:0]           sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0]           sram_rdata_i,
  output arb_state_e                      dbg_state_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  arb_state_e         state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  rsp_tag_t           tag_q [SRAM_LATENCY];
  rsp_tag_t           tag_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_we;
  logic               sel_last;
  logic [BE_W-1:0]    sel_be;
  logic               accept;

  sram_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    req_ready_o = '0;
    if (!rst_i) begin
      if (state_q == IDLE) req_ready_o = pick_any ? pick_grant : '0;
      else                 req_ready_o = req_valid_i & (NUM_REQ'(1) << owner_q);
    end
  end

  assign accept  = |req_ready_o;
  assign sel_idx = (state_q == IDLE) ? pick_idx : owner_q;

  // Steer the selected requester's slice onto the SRAM port.
  always_comb begin
    sel_we       = 1'b0;
    sel_last     = 1'b0;
    sel_be       = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_we       = req_we_i[i];
        sel_last     = req_last_i[i];
        sel_be       = req_be_i[i*BE_W +: BE_W];
        sram_addr_o  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sram_wdata_o = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sram_req_o = accept;
  assign sram_we_o  = accept & sel_we;
  assign sram_be_o  = sel_we ? sel_be : '1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (sel_last) begin
            rr_ptr_q <= IDX_W'(rr_next(TAG_IDX_W'(sel_idx), NUM_REQ));
          end else begin
            state_q <= LOCKED;
            owner_q <= sel_idx;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDX_W'(rr_next(TAG_IDX_W'(owner_q), NUM_REQ));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    tag_d.valid = accept & ~sel_we;
    tag_d.idx   = TAG_IDX_W'(sel_idx);
  end

  // Tag shift register tracks which requester owns the data arriving from the SRAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(SRAM_LATENCY); k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int k = 1; k < int'(SRAM_LATENCY); k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rsp_valid_o[i] = ~rst_i & tag_q[SRAM_LATENCY-1].valid &
                       (tag_q[SRAM_LATENCY-1].idx == TAG_IDX_W'(i));
    end
  end

  assign rsp_rdata_o = sram_rdata_i;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus a randomized run against a
// behavioural arbitration/memory model. A second instance runs with SRAM latency 2.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic                rst;
  logic [NR-1:0]       req_valid, req_we, req_last;
  logic [NR*AW-1:0]    req_addr;
  logic [NR*DW-1:0]    req_wdata;
  logic [NR*BW-1:0]    req_be;

  logic [NR-1:0]       req_ready, rsp_valid;
  logic [DW-1:0]       rsp_rdata, sram_wdata, sram_rdata;
  logic                sram_req, sram_we;
  logic [AW-1:0]       sram_addr;
  logic [BW-1:0]       sram_be;
  arb_state_e          dbg_state;

  logic [NR-1:0]       req_ready2, rsp_valid2;
  logic [DW-1:0]       rsp_rdata2, sram_wdata2, sram_rdata2;
  logic                sram_req2, sram_we2;
  logic [AW-1:0]       sram_addr2;
  logic [BW-1:0]       sram_be2;
  arb_state_e          dbg_state2;

  sram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_LATENCY(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_last_i(req_last), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
    .dbg_state_o(dbg_state)
  );

  sram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_LATENCY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready2),
    .req_we_i(req_we), .req_last_i(req_last), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(rsp_valid2), .rsp_rdata_o(rsp_rdata2),
    .sram_req_o(sram_req2), .sram_we_o(sram_we2), .sram_addr_o(sram_addr2),
    .sram_wdata_o(sram_wdata2), .sram_be_o(sram_be2), .sram_rdata_i(sram_rdata2),
    .dbg_state_o(dbg_state2)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Behavioural SRAMs, latency 1 and latency 2.
  bit   [DW-1:0] mem1 [4096];
  bit   [DW-1:0] mem2 [4096];
  logic [DW-1:0] rd1, rd2a, rd2b;
  assign sram_rdata  = rd1;
  assign sram_rdata2 = rd2b;

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) mem1[sram_addr[11:0]] <= merge(mem1[sram_addr[11:0]], sram_wdata, sram_be);
      else         rd1 <= mem1[sram_addr[11:0]];
    end
  end

  always @(posedge clk) begin
    if (sram_req2) begin
      if (sram_we2) mem2[sram_addr2[11:0]] <= merge(mem2[sram_addr2[11:0]], sram_wdata2, sram_be2);
      else          rd2a <= mem2[sram_addr2[11:0]];
    end
    rd2b <= rd2a;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input bit we, input bit last,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_last[i]            = last;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_be[i*BW +: BW]     = be;
  endtask

  task automatic idle_all();
    req_valid = '0; req_we = '0; req_last = '0;
    req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Single-beat write through the arbiter, used to preload memory contents.
  task automatic wr_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] be);
    drive(i, 1'b1, 1'b1, 1'b1, a, d, be);
    next_cycle();
    idle_all();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req got %b exp 0", sram_req); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
    next_cycle();
  endtask

  task automatic test_single_read();
    do_reset();
    wr_beat(0, 20'h10, 64'hDEADBEEF_00000001, 8'hFF);
    drive(0, 1'b1, 1'b0, 1'b1, 20'h10, '0, 8'h00);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
    checks++; if ({sram_req, sram_we} !== 2'b10) begin errors++; $display("FAIL single_sram_req_we got %b exp 10", {sram_req, sram_we}); end
    checks++; if (sram_addr !== 20'h10) begin errors++; $display("FAIL single_addr got %h exp 00010", sram_addr); end
    checks++; if (sram_be !== 8'hFF) begin errors++; $display("FAIL single_read_be got %h exp ff", sram_be); end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b exp 01", rsp_valid); end
    checks++; if (rsp_rdata !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL single_rdata got %h exp deadbeef00000001", rsp_rdata); end
    next_cycle();
  endtask

  task automatic test_alternate();
    int prev;
    logic [DW-1:0] dat [2];
    dat[0] = 64'hAAAA_0000_0000_0100;
    dat[1] = 64'hBBBB_0000_0000_0200;
    do_reset();
    wr_beat(0, 20'h100, dat[0], 8'hFF);
    wr_beat(1, 20'h200, dat[1], 8'hFF);
    drive(0, 1'b1, 1'b0, 1'b1, 20'h100, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b1, 20'h200, '0, '0);
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (req_ready !== 2'(1 << (k % 2))) begin errors++; $display("FAIL alt_grant k=%0d got %b exp %b", k, req_ready, 2'(1 << (k % 2))); end
      if (prev >= 0) begin
        checks++; if (rsp_valid !== 2'(1 << prev) || rsp_rdata !== dat[prev]) begin errors++; $display("FAIL alt_rsp k=%0d got %b/%h exp %b/%h", k, rsp_valid, rsp_rdata, 2'(1 << prev), dat[prev]); end
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL alt_rsp_first got %b exp 00", rsp_valid); end
      end
      prev = k % 2;
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== dat[1]) begin errors++; $display("FAIL alt_rsp_tail got %b/%h exp 10/%h", rsp_valid, rsp_rdata, dat[1]); end
    next_cycle();
  endtask

  task automatic test_burst_lock();
    do_reset();
    for (int b = 0; b < 4; b++) begin
      drive(0, 1'b1, 1'b1, b == 3, 20'h20 + 20'(b), 64'h1111_0000_0000_0020 + 64'(b), 8'hFF);
      if (b >= 1) drive(1, 1'b1, 1'b0, 1'b1, 20'h22, '0, '0);
      @(negedge clk);
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL burst_ready b=%0d got %b exp 01", b, req_ready); end
      next_cycle();
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL burst_req1_grant got %b exp 10", req_ready); end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 64'h1111_0000_0000_0022) begin errors++; $display("FAIL burst_readback got %b/%h exp 10/1111000000000022", rsp_valid, rsp_rdata); end
    next_cycle();
  endtask

  task automatic test_owner_gap();
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, 20'h30, 64'h3030, 8'hFF);
    drive(1, 1'b1, 1'b0, 1'b1, 20'h30, '0, '0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL gap_first got %b exp 01", req_ready); end
    next_cycle();
    drive(0, 1'b0, 1'b1, 1'b0, 20'h31, 64'h3131, 8'hFF);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      checks++; if (req_ready !== 2'b00 || sram_req !== 1'b0) begin errors++; $display("FAIL gap_stall g=%0d got ready %b req %b exp 00 0", g, req_ready, sram_req); end
      next_cycle();
    end
    drive(0, 1'b1, 1'b1, 1'b1, 20'h31, 64'h3131, 8'hFF);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL gap_last got %b exp 01", req_ready); end
    next_cycle();
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL gap_req1_grant got %b exp 10", req_ready); end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_byte_enable();
    do_reset();
    wr_beat(0, 20'h40, '1, 8'hFF);
    drive(0, 1'b1, 1'b1, 1'b1, 20'h40, 64'h11223344_55667788, 8'h0F);
    @(negedge clk);
    checks++; if (sram_be !== 8'h0F || sram_we !== 1'b1) begin errors++; $display("FAIL be_write got be %h we %b exp 0f 1", sram_be, sram_we); end
    next_cycle();
    drive(0, 1'b1, 1'b0, 1'b1, 20'h40, '0, 8'h00);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL be_read_ready got %b exp 01", req_ready); end
    next_cycle();
    idle_all();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 64'hFFFFFFFF_55667788) begin errors++; $display("FAIL be_readback got %b/%h exp 01/ffffffff55667788", rsp_valid, rsp_rdata); end
    next_cycle();
  endtask

  task automatic test_lat2_reset();
    do_reset();
    drive(0, 1'b1, 1'b0, 1'b1, 20'h50, '0, '0);
    @(negedge clk);
    checks++; if (req_ready2 !== 2'b01) begin errors++; $display("FAIL lat2_issue got %b exp 01", req_ready2); end
    next_cycle();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    checks++; if (rsp_valid2 !== 2'b00) begin errors++; $display("FAIL lat2_rsp_in_reset got %b exp 00", rsp_valid2); end
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid2 !== 2'b00) begin errors++; $display("FAIL lat2_rsp_after k=%0d got %b exp 00", k, rsp_valid2); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (dbg_state2 !== IDLE) begin errors++; $display("FAIL lat2_state got %0d exp IDLE", dbg_state2); end
    next_cycle();
    drive(0, 1'b1, 1'b0, 1'b1, 20'h50, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b1, 20'h51, '0, '0);
    @(negedge clk);
    checks++; if (req_ready2 !== 2'b01) begin errors++; $display("FAIL lat2_rr_restart got %b exp 01", req_ready2); end
    next_cycle();
    idle_all();
    repeat (3) next_cycle();
  endtask

  // Randomized traffic against a behavioural model of the arbitration rules and memory.
  task automatic test_random();
    bit [DW-1:0]   ref_mem [4096];
    int            locked, rr, g;
    int            left [NR];
    bit            bwe [NR];
    int            baddr [NR];
    logic [DW-1:0] dd [NR];
    logic [BW-1:0] dbe [NR];
    logic [NR-1:0] exp_ready;
    logic [DW-1:0] exp_q [$];
    int            exp_idx_q [$];
    int            exp_due_q [$];
    do_reset();
    locked = -1;
    rr = 0;
    for (int i = 0; i < NR; i++) left[i] = 0;
    for (int n = 0; n < 420; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (left[i] == 0 && n < 400 && $urandom_range(0, 2) == 0) begin
          left[i]  = $urandom_range(1, 4);
          bwe[i]   = 1'($urandom_range(0, 1));
          baddr[i] = 'h800 + $urandom_range(0, 60);
        end
        dd[i]  = {$urandom, $urandom};
        dbe[i] = 8'($urandom);
        drive(i, left[i] > 0 && $urandom_range(0, 3) != 0, bwe[i], left[i] == 1,
              AW'(baddr[i]), dd[i], dbe[i]);
      end
      @(negedge clk);
      exp_ready = '0;
      g = -1;
      if (locked >= 0) begin
        if (req_valid[locked]) g = locked;
      end else begin
        for (int k = 0; k < NR; k++) begin
          if (g < 0 && req_valid[(rr + k) % NR]) g = (rr + k) % NR;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, req_ready, exp_ready); end
      if (g >= 0) begin
        checks++; if (sram_req !== 1'b1 || sram_we !== bwe[g] || sram_addr !== AW'(baddr[g])) begin
          errors++; $display("FAIL rand_issue n=%0d got req %b we %b addr %h exp 1 %b %h", n, sram_req, sram_we, sram_addr, bwe[g], AW'(baddr[g]));
        end
        if (bwe[g]) begin
          checks++; if (sram_wdata !== dd[g] || sram_be !== dbe[g]) begin errors++; $display("FAIL rand_wdata n=%0d got %h/%h exp %h/%h", n, sram_wdata, sram_be, dd[g], dbe[g]); end
          ref_mem[baddr[g]] = merge(ref_mem[baddr[g]], dd[g], dbe[g]);
        end else begin
          checks++; if (sram_be !== 8'hFF) begin errors++; $display("FAIL rand_read_be n=%0d got %h exp ff", n, sram_be); end
          exp_q.push_back(ref_mem[baddr[g]]);
          exp_idx_q.push_back(g);
          exp_due_q.push_back(cyc + 1);
        end
        if (left[g] == 1) begin
          locked = -1;
          rr = (g + 1) % NR;
        end else begin
          locked = g;
        end
        left[g]--;
        baddr[g]++;
      end else begin
        checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL rand_no_issue n=%0d got %b exp 0", n, sram_req); end
      end
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        checks++; if (rsp_valid !== 2'(1 << exp_idx_q[0]) || rsp_rdata !== exp_q[0]) begin
          errors++; $display("FAIL rand_rsp n=%0d got %b/%h exp %b/%h", n, rsp_valid, rsp_rdata, 2'(1 << exp_idx_q[0]), exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
        void'(exp_due_q.pop_front());
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rand_spurious_rsp n=%0d got %b exp 00", n, rsp_valid); end
      end
      next_cycle();
    end
    checks++; if (exp_due_q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d pending exp 0", exp_due_q.size()); end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    test_reset();
    test_single_read();
    test_alternate();
    test_burst_lock();
    test_owner_gap();
    test_byte_enable();
    test_lat2_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port behavioural SRAM (req/we/addr/wdata/be/rdata, fixed read latency) between NUM_REQ requesters, e.g. the AXI BRAM controller and a preload/scrub engine in the DDR behavioural model.
- Round-robin grant with burst locking, so a multi-beat burst is never interleaved.
- Routes read data back to the issuing requester after the SRAM's fixed latency.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 20, SRAM word address width.
- DATA_WIDTH, 64, SRAM data width; BE width = DATA_WIDTH/8.
- SRAM_LATENCY, 1, cycles from accepted read to valid rdata (1..4).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_ready_o  out  NUM_REQ  per-requester beat accepted.
- req_we_i  in  NUM_REQ  1 = write beat.
- req_last_i  in  NUM_REQ  final beat of burst; releases the lock.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  word address, requester i at slice i.
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  write data.
- req_be_i  in  NUM_REQ*DATA_WIDTH/8  write byte enables.
- rsp_valid_o  out  NUM_REQ  read data valid, one pulse per read beat.
- rsp_rdata_o  out  DATA_WIDTH  read data, shared by all requesters, qualified by rsp_valid_o.
- sram_req_o  out  1  SRAM access strobe.
- sram_we_o  out  1  SRAM write.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0, response tag pipeline cleared.
  - All ready/valid/sram_req outputs are 0.
  - sram_addr/wdata/be are don't-care while sram_req_o = 0.
- Accept rule: at most one beat accepted per cycle. Beat accepted when req_valid_i[i] & req_ready_o[i].
- Ready timing: req_ready_o is combinational from req_valid_i and state; no valid-after-ready dependency is allowed on the requester side.
- Accepted beat drive (same cycle, zero latency):
  - sram_req_o = 1; sram_we_o = req_we_i[i]; sram_addr_o and sram_wdata_o from slice i.
  - sram_be_o = req_be_i[i] for writes, all ones for reads.
- IDLE:
  - Grant the first valid requester at or after rr_ptr, cyclically.
  - If the granted beat has last = 1: stay IDLE, rr_ptr <= grant+1 mod NUM_REQ.
  - Else: go to LOCKED, owner <= grant.
- LOCKED:
  - Only owner may be granted; req_ready_o = valid & (i == owner). Other requesters stall regardless of their valid.
  - If owner deasserts valid mid-burst, the lock holds and no beat is issued that cycle.
  - Owner beat with last = 1 accepted -> IDLE, rr_ptr <= owner+1.
- Simultaneous valids in IDLE: strictly round-robin. Any requester continuously valid is granted within NUM_REQ-1 bursts.
- Read response routing:
  - Each accepted read pushes {1, idx} into a SRAM_LATENCY-deep shift register; writes and idle cycles push {0, x}.
  - At the output stage: rsp_valid_o[idx] = 1 and rsp_rdata_o = sram_rdata_i.
  - No response backpressure; requesters must sink responses. Writes produce no response.
- Same-address write then read back-to-back: the read returns the new data (SRAM order is issue order).
- Reset mid-burst or with reads in flight:
  - Lock dropped, tag pipeline flushed.
  - No rsp_valid_o is asserted for beats issued before reset.
- NUM_REQ = 1: degenerates to a pass-through with a latency tag; a lock is still tracked.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {IDLE, LOCKED}.
  - rsp_tag_t struct {valid, idx[$clog2(NUM_REQ)-1:0]} (minimum idx width 1).
  - helper function rr_next(ptr, n).
- Sub-module sram_rr_pick: combinational round-robin picker with inputs valid vector and rr_ptr, outputs one-hot grant and index.
- Top module holds the FSM, lock, tag pipeline and SRAM muxing.

Test Plan:
- Single read, NUM_REQ=2, LAT=1: req0 reads addr 0x10, preloaded 0xDEADBEEF_00000001.
  -> ready0 in the same cycle; rsp_valid_o = 2'b01 one cycle later with that data.
- Both requesters valid, single-beat reads, 6 cycles.
  -> grants alternate 0,1,0,1,0,1; each rsp_valid_o bit matches its issuer.
- req0 4-beat write burst to 0x20..0x23; req1 asserts valid at beat 2.
  -> req1 ready = 0 until req0 last is accepted; req1 granted the next cycle.
- Owner gap: req0 burst deasserts valid for 3 cycles mid-burst while req1 is valid.
  -> no sram_req_o during the gap; req1 is not granted until req0 last.
- Write with be = 8'h0F, data 0x11223344_55667788, over 0xFFFF..FF, then read back.
  -> 0xFFFFFFFF_55667788.
- SRAM_LATENCY=2: reset asserted 1 cycle after a read issue.
  -> no rsp_valid_o ever; state IDLE; the next request is granted from rr_ptr = 0.
